// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B frame controller: FSM state encoding,
// default timing constants and the 24-bit GRB colour type.
package ws2812b_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    // Colour word: [23:16]=G, [15:8]=R, [7:0]=B
    typedef logic [23:0] grb_t;

    localparam int T_RESET_DEF = 2600;
    localparam int T_WDOG_DEF  = 16;
    localparam int LOAD_CYCLES = 2;

endpackage

// File: rtl/ws2812b_scale.sv
// Brightness scaling of one GRB word: each channel becomes (c*(b+1))>>8,
// so brightness 8'hFF passes the colour through unchanged.
module ws2812b_scale
    import ws2812b_pkg::*;
(
    input  grb_t       grb_in,
    input  logic [7:0] brightness,
    output grb_t       grb_out
);

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] f);
        logic [16:0] p;
        p = {9'd0, c} * {8'd0, f};
        return 8'(p >> 8);
    endfunction

    logic [8:0] factor_s;

    // One multiplier per channel, sharing the brightness factor
    always_comb begin
        factor_s = {1'b0, brightness} + 9'd1;
        grb_out  = {scale_ch(grb_in[23:16], factor_s),
                    scale_ch(grb_in[15:8],  factor_s),
                    scale_ch(grb_in[7:0],   factor_s)};
    end

endmodule

// File: rtl/pixels_frame_ctrl.sv
// WS2812B frame controller: shadow pixel buffer, frame snapshot and
// serializer handshake (IDLE -> LOAD -> SEND -> DRAIN -> LATCH).
// Optional macro WS2812B_BRIGHTNESS_EN adds a brightness input that scales
// every written colour before it is stored.
module pixels_frame_ctrl
    import ws2812b_pkg::*;
#(
    parameter int   NUM_LEDS = 4,
    parameter int   T_RESET  = T_RESET_DEF,
    parameter int   T_WDOG   = T_WDOG_DEF,
    localparam int  ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
)(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [23:0]           wr_grb,
`ifdef WS2812B_BRIGHTNESS_EN
    input  logic [7:0]            brightness,
`endif
    input  logic                  show,
    output logic                  show_ready,
    output logic                  done,
    output logic                  wdog_err,
    output logic                  ser_enable,
    output logic [NUM_LEDS*24-1:0] ser_pixels,
    input  logic                  ser_busy
);

    localparam int CNT_W = $clog2(T_RESET + T_WDOG + 2);
    localparam logic [ADDR_W:0] LED_LIMIT = (ADDR_W+1)'(NUM_LEDS);

    state_t                 state_r, state_next_s;
    logic [CNT_W-1:0]       cnt_r, cnt_next_s;
    logic                   wdog_set_s;
    logic                   show_accept_s;
    logic                   addr_ok_s;
    grb_t                   wr_data_s;
    grb_t                   shadow_r [NUM_LEDS];
    logic [NUM_LEDS*24-1:0] frame_s;
    logic                   show_ready_r, done_r, wdog_err_r, ser_enable_r;
    logic [NUM_LEDS*24-1:0] ser_pixels_r;

`ifdef WS2812B_BRIGHTNESS_EN
    ws2812b_scale u_scale (
        .grb_in     (wr_grb),
        .brightness (brightness),
        .grb_out    (wr_data_s)
    );
`else
    assign wr_data_s = wr_grb;
`endif

    assign addr_ok_s     = ({1'b0, wr_addr} < LED_LIMIT);
    assign show_accept_s = show && (state_r == ST_IDLE);

    // Shadow buffer accepts in-range writes in every state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LEDS; i++) shadow_r[i] <= '0;
        end else if (wr_en && addr_ok_s) begin
            shadow_r[wr_addr] <= wr_data_s;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) shadow_r[i] <= shadow_r[i];
        end
    end

    // Flatten the shadow buffer with pixel 0 in the MSBs
    always_comb begin
        frame_s = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            frame_s[(NUM_LEDS-i)*24-1 -: 24] = shadow_r[i];
        end
    end

    // Next-state and cycle counter for the frame sequence
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        wdog_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (show) begin
                    state_next_s = ST_LOAD;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = '0;
                end
            end
            ST_LOAD: begin
                if (cnt_r == CNT_W'(LOAD_CYCLES - 1)) begin
                    state_next_s = ST_SEND;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (ser_busy) begin
                    state_next_s = ST_DRAIN;
                    cnt_next_s   = '0;
                end else if (cnt_r == CNT_W'(T_WDOG - 1)) begin
                    state_next_s = ST_LATCH;
                    cnt_next_s   = '0;
                    wdog_set_s   = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!ser_busy) begin
                    state_next_s = ST_LATCH;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = '0;
                end
            end
            ST_LATCH: begin
                if (cnt_r == CNT_W'(T_RESET - 1)) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            show_ready_r <= 1'b1;
            done_r       <= 1'b0;
            ser_enable_r <= 1'b0;
            wdog_err_r   <= 1'b0;
            ser_pixels_r <= '0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            show_ready_r <= (state_next_s == ST_IDLE);
            done_r       <= (state_r == ST_LATCH) && (state_next_s == ST_IDLE);
            ser_enable_r <= (state_next_s == ST_SEND) || (state_next_s == ST_DRAIN);
            if (show_accept_s) begin
                wdog_err_r   <= 1'b0;
                ser_pixels_r <= frame_s;
            end else if (wdog_set_s) begin
                wdog_err_r   <= 1'b1;
                ser_pixels_r <= ser_pixels_r;
            end else begin
                wdog_err_r   <= wdog_err_r;
                ser_pixels_r <= ser_pixels_r;
            end
        end
    end

    assign show_ready = show_ready_r;
    assign done       = done_r;
    assign wdog_err   = wdog_err_r;
    assign ser_enable = ser_enable_r;
    assign ser_pixels = ser_pixels_r;

endmodule

// File: tb/tb_pixels_frame_ctrl.sv
// Self-checking bench for pixels_frame_ctrl: table-driven frames with a
// snapshot scoreboard, plus watchdog, same-cycle write, reset-abort and
// out-of-range address sequences. Builds with or without WS2812B_BRIGHTNESS_EN.
module tb_pixels_frame_ctrl;

    localparam int T_RESET = 2600;
    localparam int T_WDOG  = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_en, show, ser_busy;
    logic [1:0]  wr_addr;
    logic [23:0] wr_grb;
    logic        show_ready, done, wdog_err, ser_enable;
    logic [95:0] ser_pixels;

    logic        wr_en5, show5;
    logic [2:0]  wr_addr5;
    logic [23:0] wr_grb5;
    logic        show_ready5, done5, wdog_err5, ser_enable5;
    logic [119:0] ser_pixels5;
`ifdef WS2812B_BRIGHTNESS_EN
    logic [7:0]  brightness;
`endif

    int checks   = 0;
    int failures = 0;
    logic [95:0] sb [$];

    always #5 clock = ~clock;

    pixels_frame_ctrl #(.NUM_LEDS(4), .T_RESET(T_RESET), .T_WDOG(T_WDOG)) dut (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_grb(wr_grb),
`ifdef WS2812B_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .show(show), .show_ready(show_ready), .done(done), .wdog_err(wdog_err),
        .ser_enable(ser_enable), .ser_pixels(ser_pixels), .ser_busy(ser_busy)
    );

    pixels_frame_ctrl #(.NUM_LEDS(5), .T_RESET(8), .T_WDOG(4)) dut5 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en5), .wr_addr(wr_addr5),
        .wr_grb(wr_grb5),
`ifdef WS2812B_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .show(show5), .show_ready(show_ready5), .done(done5), .wdog_err(wdog_err5),
        .ser_enable(ser_enable5), .ser_pixels(ser_pixels5), .ser_busy(1'b0)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [23:0] grb;
        bit          do_show;
        int          busy_len;
        logic [95:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Call at posedge+1 with the DUT idle; expected snapshot already queued.
    task automatic run_frame(input bit sc_wr, input logic [1:0] sc_addr,
                             input logic [23:0] sc_grb, input int busy_len,
                             input bit exp_wdog);
        logic [95:0] exp_frame;
        int n;
        bit seen;
        show = 1'b1; wr_en = sc_wr; wr_addr = sc_addr; wr_grb = sc_grb;
        @(posedge clock); #1;
        show = 1'b0; wr_en = 1'b0;
        @(negedge clock);
        check("load1_enable", ser_enable, 0);
        check("load1_ready", show_ready, 0);
        check("wdog_cleared", wdog_err, 0);
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            exp_frame = sb.pop_front();
            check("snapshot", ser_pixels, exp_frame);
        end
        @(negedge clock);
        check("load2_enable", ser_enable, 0);
        @(negedge clock);
        check("send_enable", ser_enable, 1);
        if (!exp_wdog) begin
            ser_busy = 1'b1;
            repeat (busy_len) @(posedge clock);
            #1 ser_busy = 1'b0;
            @(negedge clock);
            check("drain_enable", ser_enable, 1);
            @(negedge clock);
            check("latch_enable", ser_enable, 0);
        end else begin
            n = 0; seen = 1'b0;
            for (int i = 1; i <= T_WDOG + 4 && !seen; i++) begin
                @(negedge clock);
                if (!ser_enable) begin seen = 1'b1; n = i; end
            end
            check("wdog_cycles", n, T_WDOG);
            check("wdog_err_set", wdog_err, 1);
        end
        n = 0; seen = 1'b0;
        for (int i = 1; i <= T_RESET + 8 && !seen; i++) begin
            @(negedge clock);
            if (done) begin seen = 1'b1; n = i; end
        end
        check("latch_length", n, T_RESET);
        @(negedge clock);
        check("done_one_cycle", done, 0);
        check("ready_again", show_ready, 1);
        if (exp_wdog) check("wdog_sticky", wdog_err, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [5];
        int n;
        vecs[0] = '{2'd0, 24'hFF0000, 1'b0, 0,    96'h0};
        vecs[1] = '{2'd3, 24'h0000FF, 1'b1, 6144, 96'hFF0000_000000_000000_0000FF};
        vecs[2] = '{2'd2, 24'h00FF00, 1'b1, 30,   96'hFF0000_000000_00FF00_0000FF};
        vecs[3] = '{2'd0, 24'h123456, 1'b0, 0,    96'h0};
        vecs[4] = '{2'd3, 24'hABCDEF, 1'b1, 10,   96'h123456_000000_00FF00_ABCDEF};

        reset_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_grb = 24'd0;
        show = 1'b0; ser_busy = 1'b0;
        wr_en5 = 1'b0; wr_addr5 = 3'd0; wr_grb5 = 24'd0; show5 = 1'b0;
`ifdef WS2812B_BRIGHTNESS_EN
        brightness = 8'hFF;
`endif
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst_show_ready", show_ready, 1);
        check("rst_ser_enable", ser_enable, 0);
        check("rst_done", done, 0);
        check("rst_wdog_err", wdog_err, 0);
        check("rst_ser_pixels", ser_pixels, 0);
        @(posedge clock); #1;

        // Table: each row writes one pixel; some rows then send a frame
        for (int v = 0; v < 5; v++) begin
            wr_en = 1'b1; wr_addr = vecs[v].addr; wr_grb = vecs[v].grb;
            @(posedge clock); #1 wr_en = 1'b0;
            if (vecs[v].do_show) begin
                sb.push_back(vecs[v].exp);
                run_frame(1'b0, 2'd0, 24'd0, vecs[v].busy_len, 1'b0);
            end
        end

        // Show while not idle must be ignored (frame in LATCH here)
        sb.push_back(96'h123456_000000_00FF00_ABCDEF);
        show = 1'b1;
        @(posedge clock); #1 show = 1'b0;
        repeat (3) @(posedge clock);
        #1 ser_busy = 1'b1;
        repeat (4) @(posedge clock);
        #1 ser_busy = 1'b0;
        @(posedge clock); #1 show = 1'b1;
        @(posedge clock); #1 show = 1'b0;
        @(negedge clock);
        check("busy_show_ignored", show_ready, 0);
        n = 0;
        for (int i = 1; i <= T_RESET + 8 && n == 0; i++) begin
            @(negedge clock);
            if (done) n = i;
        end
        check("ignored_show_idle", n != 0, 1);
        @(negedge clock);
        check("no_queued_frame", show_ready, 1);
        void'(sb.pop_front());
        @(posedge clock); #1;

        // Watchdog: serializer never reports busy
        sb.push_back(96'h123456_000000_00FF00_ABCDEF);
        run_frame(1'b0, 2'd0, 24'd0, 0, 1'b1);

        // Same-cycle write goes to shadow only; wdog_err cleared by this show
        sb.push_back(96'h123456_000000_00FF00_ABCDEF);
        run_frame(1'b1, 2'd1, 24'h777777, 5, 1'b0);
        sb.push_back(96'h123456_777777_00FF00_ABCDEF);
        run_frame(1'b0, 2'd0, 24'd0, 5, 1'b0);

        // Reset asserted during DRAIN aborts the frame with no done
        show = 1'b1;
        @(posedge clock); #1 show = 1'b0;
        repeat (2) @(posedge clock);
        #1 ser_busy = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("drain_before_reset", ser_enable, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_ser_enable", ser_enable, 0);
        check("async_show_ready", show_ready, 1);
        check("async_done", done, 0);
        check("async_wdog_err", wdog_err, 0);
        check("async_ser_pixels", ser_pixels, 0);
        @(posedge clock); #1;
        reset_n = 1'b1; ser_busy = 1'b0;
        n = 0;
        for (int i = 0; i < T_RESET + 20; i++) begin
            @(negedge clock);
            if (done) n++;
        end
        check("no_done_after_reset", n, 0);
        @(posedge clock); #1;
        sb.push_back(96'h0);
        run_frame(1'b0, 2'd0, 24'd0, 5, 1'b0);

`ifdef WS2812B_BRIGHTNESS_EN
        brightness = 8'h7F;
        wr_en = 1'b1; wr_addr = 2'd0; wr_grb = 24'hFF8040;
        @(posedge clock); #1 wr_en = 1'b0;
        sb.push_back(96'h7F4020_000000_000000_000000);
        run_frame(1'b0, 2'd0, 24'd0, 5, 1'b0);
        brightness = 8'hFF;
`endif

        // Five-pixel instance: addresses 5 and 7 are out of range
        for (int i = 0; i < 4; i++) begin
            logic [2:0]  a5 [4];
            logic [23:0] g5 [4];
            a5[0] = 3'd0; a5[1] = 3'd4; a5[2] = 3'd5; a5[3] = 3'd7;
            g5[0] = 24'h010203; g5[1] = 24'h123456; g5[2] = 24'hABCDEF; g5[3] = 24'hFFFFFF;
            wr_en5 = 1'b1; wr_addr5 = a5[i]; wr_grb5 = g5[i];
            @(posedge clock); #1 wr_en5 = 1'b0;
        end
        show5 = 1'b1;
        @(posedge clock); #1 show5 = 1'b0;
        @(negedge clock);
        check("oob_snapshot", ser_pixels5, 120'h010203_000000_000000_000000_123456);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clock);
            if (done5) n = i;
        end
        check("dut5_done_seen", n != 0, 1);
        check("dut5_wdog", wdog_err5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixels_frame_ctrl.md
PIXELS_FRAME_CTRL -- requirements
Module: pixels_frame_ctrl

Interface
REQ-001 SHALL: parameter NUM_LEDS, default 4, number of chained WS2812B pixels (1..10).
REQ-002 SHALL: parameter T_RESET, default 2600, latch-gap length in clocks (52 µs at 50 MHz).
REQ-003 SHALL: parameter T_WDOG, default 16, clocks allowed for the serializer to report busy.
REQ-004 SHALL: one clock; reset is asynchronous and active-low; ports are named clock and reset_n.
REQ-005 SHALL: clock  input  1  50 MHz system clock, all state on posedge.
REQ-006 SHALL: reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL: wr_en  input  1  pixel write strobe, one write per cycle.
REQ-008 SHALL: wr_addr  input  ADDR_W  pixel index, ADDR_W = max(1, clog2(NUM_LEDS)).
REQ-009 SHALL: wr_grb  input  24  colour, [23:16]=G, [15:8]=R, [7:0]=B.
REQ-010 SHALL: show  input  1  request to transmit the current shadow frame.
REQ-011 SHALL: show_ready  output  1  high only in IDLE; show accepted when show && show_ready.
REQ-012 SHALL: done  output  1  one-cycle pulse when a frame plus latch gap completes.
REQ-013 SHALL: wdog_err  output  1  sticky, set on watchdog expiry, cleared by accepted show.
REQ-014 SHALL: ser_enable  output  1  enable to the downstream bit serializer.
REQ-015 SHALL: ser_pixels  output  NUM_LEDS*24  frame to serializer; pixel 0 in the MSBs (sent first).
REQ-016 SHALL: ser_busy  input  1  serializer bit_ready (high while shifting bits).

Function
REQ-017 SHALL: hold a shadow buffer of NUM_LEDS x 24 bits; writes land there in every state.
REQ-018 SHALL: ignore writes with wr_addr >= NUM_LEDS.
REQ-019 SHALL: on accepted show, copy shadow into ser_pixels in that cycle; a same-cycle write updates shadow only (not the snapshot).
REQ-020 SHALL: pixel i occupies ser_pixels[(NUM_LEDS-i)*24-1 -: 24].
REQ-021 SHALL: FSM states IDLE, LOAD, SEND, DRAIN, LATCH.
REQ-022 SHALL: IDLE -> LOAD on accepted show; ser_enable=0 in IDLE.
REQ-023 SHALL: LOAD lasts exactly 2 clocks, ser_enable=0, so the serializer samples ser_pixels on a negedge.
REQ-024 SHALL: SEND drives ser_enable=1; -> DRAIN when ser_busy seen high; -> LATCH with wdog_err=1 if not seen within T_WDOG clocks.
REQ-025 SHALL: DRAIN keeps ser_enable=1; -> LATCH on first cycle ser_busy is low.
REQ-026 SHALL: LATCH drives ser_enable=0 for exactly T_RESET clocks, then -> IDLE with done=1 on the IDLE-entry cycle.
REQ-027 SHALL: show asserted outside IDLE is ignored, not queued.

Reset
REQ-028 SHALL: asynchronous reset_n low forces IDLE; ser_enable=0, show_ready=1 after release, done=0, wdog_err=0, ser_pixels=0, shadow=0, counters=0.
REQ-029 SHALL: reset mid-frame abort immediately; no done pulse follows.

Configuration
REQ-030 SHALL: macro WS2812B_BRIGHTNESS_EN adds input brightness[7:0]; each written channel is stored as (c*(brightness+1))>>8.
REQ-031 SHALL: without WS2812B_BRIGHTNESS_EN the port is absent and wr_grb is stored verbatim.

Structure
REQ-032 SHALL: package ws2812b_pkg holds the FSM state encoding, T_RESET/T_WDOG defaults and 24-bit colour typedef.
REQ-033 SHALL: channel scaling lives in sub-module ws2812b_scale (3 multipliers), instantiated only under the macro.

Verification
REQ-034 SHALL: write addr 0=24'hFF0000, addr 3=24'h0000FF, show -> ser_pixels=96'hFF0000_000000_000000_0000FF, ser_enable low 2 clocks then high.
REQ-035 SHALL: model ser_busy high 6144 clocks -> ser_enable falls 1 clock after ser_busy falls, done pulses 2600 clocks later.
REQ-036 SHALL: ser_busy tied low -> wdog_err=1 after 16 SEND clocks, LATCH entered, cleared on next accepted show.
REQ-037 SHALL: write addr 1 with show in same cycle -> snapshot holds old addr 1, next frame holds new value; write addr 5 -> no change.
REQ-038 SHALL: reset_n low during DRAIN -> ser_enable=0 asynchronously, all outputs at reset values, no done.
REQ-039 SHALL: with WS2812B_BRIGHTNESS_EN, brightness=8'h7F, wr_grb=24'hFF8040 -> stored 24'h7F4020.
